// File: rtl/char_ctl.sv
// Per-frame character motion controller: walking, jump and gravity.
// All state advances once per vsync rising edge; outputs are registered.
module char_ctl #(
  parameter int HOR_PIXELS = 800,
  parameter int VER_PIXELS = 600,
  parameter int GROUND_Y   = 550,
  parameter int HGT_RST    = 26,
  parameter int MOVE_STEP  = 4,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic [11:0] char_lng,
  input  logic [11:0] char_hgt,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        flip_h,
  output logic        on_ground
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  localparam logic signed [12:0] HOR_S   = 13'(HOR_PIXELS);
  localparam logic signed [12:0] GND_S   = 13'(GROUND_Y);
  localparam logic signed [12:0] STEP_S  = 13'(MOVE_STEP);
  localparam logic [11:0]        X_RST   = 12'(HOR_PIXELS / 2);
  localparam logic [11:0]        Y_RST   = 12'(GROUND_Y - HGT_RST);
  localparam logic [4:0]         JUMP_V  = 5'(JUMP_VEL);
  localparam logic [4:0]         GRAV_V  = 5'(GRAVITY);
  localparam logic [4:0]         MAXF_V  = 5'(MAX_FALL);

  state_t             state_r, state_nxt_s;
  logic [4:0]         vel_r, vel_nxt_s, vel_dec_s, fall_v_s;
  logic               armed_r, armed_nxt_s;
  logic               vsync_q_r;
  logic               tick_s;
  logic [11:0]        x_nxt_s, y_nxt_s;
  logic               flip_nxt_s;
  logic signed [12:0] x_cur_s, x_mv_s, lng_s, x_hi_s;
  logic signed [12:0] y_cur_s, hgt_s, gy_s, vel_s, fall_s, y_rise_s, y_fall_s;

  // Next-state computation: horizontal walk with clamp, vertical jump FSM
  always_comb begin
    tick_s      = vsync & ~vsync_q_r;
    state_nxt_s = state_r;
    vel_nxt_s   = vel_r;
    armed_nxt_s = armed_r;
    x_nxt_s     = pos_x;
    y_nxt_s     = pos_y;
    flip_nxt_s  = flip_h;
    x_cur_s     = $signed({1'b0, pos_x});
    y_cur_s     = $signed({1'b0, pos_y});
    lng_s       = $signed({1'b0, char_lng});
    hgt_s       = $signed({1'b0, char_hgt});
    x_hi_s      = HOR_S - lng_s;
    gy_s        = GND_S - hgt_s;
    vel_s       = $signed({8'b0, vel_r});
    vel_dec_s   = vel_r - GRAV_V;
    fall_v_s    = ((vel_r + GRAV_V) > MAXF_V) ? MAXF_V : (vel_r + GRAV_V);
    fall_s      = $signed({8'b0, fall_v_s});
    y_rise_s    = y_cur_s - vel_s;
    y_fall_s    = y_cur_s + fall_s;
    x_mv_s      = x_cur_s;

    if (tick_s) begin
      if (!btn_jump) begin
        armed_nxt_s = 1'b1;
      end else begin
        armed_nxt_s = armed_r;
      end

      if (btn_left && !btn_right) begin
        x_mv_s     = x_cur_s - STEP_S;
        flip_nxt_s = 1'b1;
      end else if (btn_right && !btn_left) begin
        x_mv_s     = x_cur_s + STEP_S;
        flip_nxt_s = 1'b0;
      end else begin
        x_mv_s     = x_cur_s;
        flip_nxt_s = flip_h;
      end

      // Signed compare keeps a step past the left edge from wrapping
      if (x_mv_s < lng_s) begin
        x_nxt_s = lng_s[11:0];
      end else if (x_mv_s > x_hi_s) begin
        x_nxt_s = x_hi_s[11:0];
      end else begin
        x_nxt_s = x_mv_s[11:0];
      end

      case (state_r)
        GROUND: begin
          if (btn_jump && armed_r) begin
            state_nxt_s = RISE;
            vel_nxt_s   = JUMP_V;
            armed_nxt_s = 1'b0;
          end else begin
            state_nxt_s = GROUND;
          end
        end
        RISE: begin
          if (y_rise_s <= hgt_s) begin
            y_nxt_s     = char_hgt;
            vel_nxt_s   = 5'd0;
            state_nxt_s = FALL;
          end else begin
            y_nxt_s   = y_rise_s[11:0];
            vel_nxt_s = vel_dec_s;
            if (vel_dec_s == 5'd0) begin
              state_nxt_s = FALL;
            end else begin
              state_nxt_s = RISE;
            end
          end
        end
        FALL: begin
          if (y_fall_s >= gy_s) begin
            y_nxt_s     = gy_s[11:0];
            vel_nxt_s   = 5'd0;
            state_nxt_s = GROUND;
          end else begin
            y_nxt_s   = y_fall_s[11:0];
            vel_nxt_s = fall_v_s;
          end
        end
        default: begin
          state_nxt_s = GROUND;
          vel_nxt_s   = 5'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= GROUND;
      vel_r     <= 5'd0;
      armed_r   <= 1'b0;
      vsync_q_r <= 1'b0;
      pos_x     <= X_RST;
      pos_y     <= Y_RST;
      flip_h    <= 1'b0;
      on_ground <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      vel_r     <= vel_nxt_s;
      armed_r   <= armed_nxt_s;
      vsync_q_r <= vsync;
      pos_x     <= x_nxt_s;
      pos_y     <= y_nxt_s;
      flip_h    <= flip_nxt_s;
      on_ground <= (state_nxt_s == GROUND);
    end
  end

  logic unused_s;
  assign unused_s = ^{VER_PIXELS[0]};

endmodule
